// File: rtl/branch_resolve.sv
// Branch resolution for the MEM stage: evaluates the branch condition,
// registers the redirect target and drives PC-select / flush sequencing.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   valid_in        MEM-stage instruction valid
//   branch_op[2:0]  condition select (none/beq/bne/blez/bgtz/bltz/bgez/jump)
//   zero, sign      ALU result flags
//   target          computed branch target
//   stall           pipeline hold (blocks acceptance, freezes sequencing)
//   PCSrc           registered PC-select, high for the redirect cycle
//   target_out      registered redirect address
//   flush           squash IF/ID/EX, high FLUSH_DEPTH unstalled cycles
//   taken_count     saturating count of taken branches
//   busy            high while not idle
module branch_resolve #(
    parameter int ADDR_W      = 32,
    parameter int FLUSH_DEPTH = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [2:0]        branch_op,
    input  logic              zero,
    input  logic              sign,
    input  logic [ADDR_W-1:0] target,
    input  logic              stall,
    output logic              PCSrc,
    output logic [ADDR_W-1:0] target_out,
    output logic              flush,
    output logic [CNT_W-1:0]  taken_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDIRECT,
        S_FLUSH
    } state_t;

    // Cycles left in S_FLUSH after the redirect cycle.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

    state_t     state;
    logic [2:0] remaining;
    logic       cond;

    always_comb begin
        cond = 1'b0;
        unique case (branch_op)
            3'b000: cond = 1'b0;
            3'b001: cond = zero;
            3'b010: cond = ~zero;
            3'b011: cond = zero | sign;
            3'b100: cond = ~zero & ~sign;
            3'b101: cond = sign;
            3'b110: cond = ~sign;
            3'b111: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            remaining   <= 3'd0;
            PCSrc       <= 1'b0;
            flush       <= 1'b0;
            target_out  <= '0;
            taken_count <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (valid_in && !stall && cond) begin
                        state      <= S_REDIRECT;
                        PCSrc      <= 1'b1;
                        flush      <= 1'b1;
                        target_out <= target;
                        if (taken_count != '1)
                            taken_count <= taken_count + CNT_W'(1);
                    end
                end
                S_REDIRECT: begin
                    if (!stall) begin
                        PCSrc <= 1'b0;
                        if (FLUSH_DEPTH <= 1) begin
                            state <= S_IDLE;
                            flush <= 1'b0;
                        end else begin
                            state     <= S_FLUSH;
                            remaining <= FLUSH_LOAD;
                        end
                    end
                end
                S_FLUSH: begin
                    if (!stall) begin
                        // Last flush cycle: count hits zero on this edge.
                        if (remaining <= 3'd1) begin
                            state     <= S_IDLE;
                            remaining <= 3'd0;
                            flush     <= 1'b0;
                        end else begin
                            remaining <= remaining - 3'd1;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    remaining <= 3'd0;
                    PCSrc     <= 1'b0;
                    flush     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: vector table on a default
// instance, plus a CNT_W=2 / FLUSH_DEPTH=1 instance for saturation.
module tb_branch_resolve;

    typedef struct {
        logic        which;
        logic        rst_n;
        logic        valid;
        logic [2:0]  op;
        logic        zero;
        logic        sign;
        logic [31:0] tgt;
        logic        stall;
        logic        pc;
        logic        fl;
        logic        bz;
        logic [31:0] tout;
        logic [15:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n = 1'b0, a_valid = 1'b0, a_zero = 1'b0;
    logic        a_sign = 1'b0, a_stall = 1'b0;
    logic [2:0]  a_op = 3'd0;
    logic [31:0] a_tgt = 32'd0;
    logic        a_pc, a_fl, a_bz;
    logic [31:0] a_tout;
    logic [15:0] a_cnt;

    logic        b_rst_n = 1'b0, b_valid = 1'b0, b_zero = 1'b0;
    logic        b_sign = 1'b0, b_stall = 1'b0;
    logic [2:0]  b_op = 3'd0;
    logic [31:0] b_tgt = 32'd0;
    logic        b_pc, b_fl, b_bz;
    logic [31:0] b_tout;
    logic [1:0]  b_cnt;

    branch_resolve dut_a (
        .clk(clk), .rst_n(a_rst_n), .valid_in(a_valid),
        .branch_op(a_op), .zero(a_zero), .sign(a_sign),
        .target(a_tgt), .stall(a_stall), .PCSrc(a_pc),
        .target_out(a_tout), .flush(a_fl),
        .taken_count(a_cnt), .busy(a_bz)
    );

    branch_resolve #(.ADDR_W(32), .FLUSH_DEPTH(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .valid_in(b_valid),
        .branch_op(b_op), .zero(b_zero), .sign(b_sign),
        .target(b_tgt), .stall(b_stall), .PCSrc(b_pc),
        .target_out(b_tout), .flush(b_fl),
        .taken_count(b_cnt), .busy(b_bz)
    );

    int checks = 0;
    int failures = 0;
    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(
        input logic w, input logic r, input logic v,
        input logic [2:0] o, input logic z, input logic s,
        input logic [31:0] t, input logic st,
        input logic p, input logic f, input logic b,
        input logic [31:0] to, input logic [15:0] c);
        vec_t x;
        x.which = w; x.rst_n = r; x.valid = v; x.op = o;
        x.zero = z; x.sign = s; x.tgt = t; x.stall = st;
        x.pc = p; x.fl = f; x.bz = b; x.tout = to; x.cnt = c;
        return x;
    endfunction

    task automatic cmp(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h",
                     nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        logic [31:0] pc, fl, bz, to, cn;
        @(negedge clk);
        if (v.which == 1'b0) begin
            a_rst_n = v.rst_n; a_valid = v.valid; a_op = v.op;
            a_zero = v.zero; a_sign = v.sign; a_tgt = v.tgt;
            a_stall = v.stall;
        end else begin
            b_rst_n = v.rst_n; b_valid = v.valid; b_op = v.op;
            b_zero = v.zero; b_sign = v.sign; b_tgt = v.tgt;
            b_stall = v.stall;
        end
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty step %0d", idx);
            return;
        end
        e = sb.pop_front();
        if (e.which == 1'b0) begin
            pc = 32'(a_pc); fl = 32'(a_fl); bz = 32'(a_bz);
            to = a_tout; cn = 32'(a_cnt);
        end else begin
            pc = 32'(b_pc); fl = 32'(b_fl); bz = 32'(b_bz);
            to = b_tout; cn = 32'(b_cnt);
        end
        cmp("PCSrc", idx, pc, 32'(e.pc));
        cmp("flush", idx, fl, 32'(e.fl));
        cmp("busy", idx, bz, 32'(e.bz));
        cmp("target_out", idx, to, e.tout);
        cmp("taken_count", idx, cn, 32'(e.cnt));
    endtask

    initial begin
        // which rst valid op zero sign tgt stall | pc fl busy tout cnt
        tbl.push_back(mk(0,0,0,3'd0,0,0,32'h0,0, 0,0,0,32'h0,0));
        tbl.push_back(mk(0,1,1,3'd1,1,0,32'h40,0, 1,1,1,32'h40,1));
        tbl.push_back(mk(0,1,0,3'd0,0,0,32'h0,0, 0,1,1,32'h40,1));
        tbl.push_back(mk(0,1,0,3'd0,0,0,32'h0,0, 0,1,1,32'h40,1));
        tbl.push_back(mk(0,1,0,3'd0,0,0,32'h0,0, 0,0,0,32'h40,1));
        tbl.push_back(mk(0,1,1,3'd2,1,0,32'h80,0, 0,0,0,32'h40,1));
        tbl.push_back(mk(0,1,1,3'd3,0,0,32'h80,0, 0,0,0,32'h40,1));
        tbl.push_back(mk(0,1,1,3'd0,1,1,32'h80,0, 0,0,0,32'h40,1));
        tbl.push_back(mk(0,1,0,3'd1,1,0,32'h80,0, 0,0,0,32'h40,1));
        tbl.push_back(mk(0,1,1,3'd4,0,0,32'h100,0, 1,1,1,32'h100,2));
        tbl.push_back(mk(0,1,0,3'd0,0,0,32'h0,0, 0,1,1,32'h100,2));
        tbl.push_back(mk(0,1,0,3'd0,0,0,32'h0,1, 0,1,1,32'h100,2));
        tbl.push_back(mk(0,1,0,3'd0,0,0,32'h0,1, 0,1,1,32'h100,2));
        tbl.push_back(mk(0,1,0,3'd0,0,0,32'h0,0, 0,1,1,32'h100,2));
        tbl.push_back(mk(0,1,0,3'd0,0,0,32'h0,0, 0,0,0,32'h100,2));
        tbl.push_back(mk(0,1,1,3'd7,0,0,32'h200,0, 1,1,1,32'h200,3));
        tbl.push_back(mk(0,1,1,3'd1,1,0,32'h300,0, 0,1,1,32'h200,3));
        tbl.push_back(mk(0,1,1,3'd1,1,0,32'h300,0, 0,1,1,32'h200,3));
        tbl.push_back(mk(0,1,1,3'd1,1,0,32'h300,0, 0,0,0,32'h200,3));
        tbl.push_back(mk(0,1,1,3'd5,0,1,32'h400,1, 0,0,0,32'h200,3));
        tbl.push_back(mk(0,1,1,3'd5,0,1,32'h400,0, 1,1,1,32'h400,4));
        tbl.push_back(mk(0,1,0,3'd0,0,0,32'h0,1, 1,1,1,32'h400,4));
        tbl.push_back(mk(0,1,0,3'd0,0,0,32'h0,0, 0,1,1,32'h400,4));
        tbl.push_back(mk(0,0,1,3'd7,0,0,32'h999,0, 0,0,0,32'h0,0));
        tbl.push_back(mk(0,1,1,3'd6,0,0,32'h500,0, 1,1,1,32'h500,1));
        tbl.push_back(mk(0,0,1,3'd7,0,0,32'h999,0, 0,0,0,32'h0,0));
        tbl.push_back(mk(0,1,1,3'd6,0,1,32'h500,0, 0,0,0,32'h0,0));
        tbl.push_back(mk(0,1,1,3'd5,0,0,32'h500,0, 0,0,0,32'h0,0));
        tbl.push_back(mk(0,1,1,3'd3,0,1,32'h600,0, 1,1,1,32'h600,1));

        // Depth-1 instance: redirect returns straight to idle and the
        // 2-bit counter sticks at 3.
        tbl.push_back(mk(1,0,0,3'd0,0,0,32'h0,0, 0,0,0,32'h0,0));
        for (int k = 0; k < 5; k++) begin
            logic [15:0] c;
            c = (k < 3) ? 16'(k + 1) : 16'd3;
            tbl.push_back(mk(1,1,1,3'd7,0,0,32'(k + 1),0,
                             1,1,1,32'(k + 1),c));
            tbl.push_back(mk(1,1,0,3'd0,0,0,32'h0,0,
                             0,0,0,32'(k + 1),c));
        end

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        cmp("scoreboard_drained", tbl.size(), 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter ADDR_W, default 32, width of branch target address.
REQ-002 Parameter FLUSH_DEPTH, default 3, total cycles flush is asserted per taken branch; legal range 1..7.
REQ-003 Parameter CNT_W, default 16, width of taken-branch statistics counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 valid_in  input  1  MEM-stage instruction valid.
REQ-007 branch_op  input  3  condition select:
  - 000 none
  - 001 beq
  - 010 bne
  - 011 blez
  - 100 bgtz
  - 101 bltz
  - 110 bgez
  - 111 unconditional jump
REQ-008 zero  input  1  ALU result equals zero.
REQ-009 sign  input  1  ALU result bit 31 (negative).
REQ-010 target  input  ADDR_W  computed branch target.
REQ-011 stall  input  1  pipeline hold; when 1, no new branch is accepted and the flush count freezes.
REQ-012 PCSrc  output  1  registered PC-select (1 = load target_out).
REQ-013 target_out  output  ADDR_W  registered redirect address.
REQ-014 flush  output  1  squash IF/ID/EX stages.
REQ-015 taken_count  output  CNT_W  saturating count of taken branches.
REQ-016 busy  output  1  high while state is not IDLE.

Function
REQ-017 Condition taken per branch_op:
  - beq = zero
  - bne = ~zero
  - blez = zero|sign
  - bgtz = ~zero&~sign
  - bltz = sign
  - bgez = ~sign
  - jump = 1
  - none = 0
REQ-018 FSM states: IDLE, REDIRECT, FLUSH.
REQ-019 Acceptance occurs only in IDLE, on an edge where valid_in=1, stall=0 and the REQ-017 condition is true.
REQ-020 On acceptance: target_out<=target, taken_count increments, state enters REDIRECT.
REQ-021 Latency: PCSrc=1 and flush=1 appear exactly 1 cycle after the accepting edge.
REQ-022 REDIRECT: PCSrc=1, flush=1.
  - If stall=1, remain in REDIRECT with outputs held.
  - Else if FLUSH_DEPTH=1, go to IDLE.
  - Else go to FLUSH with the remaining-count loaded to FLUSH_DEPTH-1.
REQ-023 FLUSH: PCSrc=0, flush=1.
  - The remaining-count decrements on each edge with stall=0.
  - When the count reaches 0, go to IDLE.
  - stall=1 freezes the count.
REQ-024 IDLE: PCSrc=0, flush=0; target_out holds its last value.
REQ-025 Not-taken or invalid instruction: no state change, no counter change, no output change.
REQ-026 Branch inputs presented in REDIRECT or FLUSH are ignored (squashed instructions), even if their condition is true.
REQ-027 taken_count saturates at all-ones and never wraps.
REQ-028 busy = (state != IDLE), decoded combinationally from registered state.
REQ-029 Inputs valid_in=1 with stall=1 in IDLE: the branch is not accepted; it is accepted on the first edge with stall=0 if inputs are still presented.

Reset
REQ-030 When rst_n=0 at a rising edge, reset occurs regardless of other inputs:
  - state=IDLE
  - PCSrc=0, flush=0, busy=0
  - target_out=0, taken_count=0
  - remaining-count=0
REQ-031 Reset asserted mid-REDIRECT or mid-FLUSH aborts the sequence; outputs are 0 on the cycle after the reset edge.
REQ-032 The first acceptance is possible on the first edge with rst_n=1.

Verification
REQ-033 Reset then beq, zero=1, target=0x00000040, valid_in=1 -> next cycle PCSrc=1, flush=1, target_out=0x40; flush high exactly 3 cycles; taken_count=1.
REQ-034 bne with zero=1, then blez with zero=0, sign=0 -> PCSrc, flush and busy stay 0; taken_count unchanged.
REQ-035 bgtz taken; stall=1 for 2 cycles during FLUSH -> flush high 5 cycles total; PCSrc high 1 cycle.
REQ-036 Taken jump, then a taken beq presented during FLUSH -> second branch ignored; taken_count=1; IDLE after 3 flush cycles.
REQ-037 Build with CNT_W=2; 5 back-to-back taken jumps (each after return to IDLE) -> taken_count sticks at 3.
REQ-038 rst_n=0 during REDIRECT -> next cycle PCSrc=0, flush=0, taken_count=0, busy=0.
